// File: rtl/pingpong_blk_assembler_pkg.sv
// Shared constants, bank index type and counter-width helper for the ping/pong block assembler.
package pingpong_blk_assembler_pkg;

    localparam int unsigned SUB_BLK_BIT = 32;
    localparam int unsigned PPA_NUM_SUB = 16;
    localparam int unsigned PPA_LAT     = 6;

    typedef enum logic {
        BankPing = 1'b0,
        BankPong = 1'b1
    } bank_e;

    // Bits needed to count 0..n-1; never less than one.
    function automatic int unsigned ppa_log2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ppa_delay_line.sv
// LAT-deep single-bit shift register with asynchronous active-low clear; tap is the oldest stage.
module ppa_delay_line #(
    parameter int unsigned LAT = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [LAT-1:0] sr_q;

    if (LAT == 1) begin : g_one
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sr_q <= '0;
            end else begin
                sr_q <= din;
            end
        end
    end else begin : g_multi
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sr_q <= '0;
            end else begin
                sr_q <= {sr_q[LAT-2:0], din};
            end
        end
    end

    assign dout = sr_q[LAT-1];

endmodule

// File: rtl/pingpong_blk_assembler.sv
// Packs NUM_SUB pipe-aligned sub-blocks into ping/pong banks with credit-based issue control.
// Optional macro PPA_PARITY_EN adds a per-slice even-parity output (out_parity).
module pingpong_blk_assembler
    import pingpong_blk_assembler_pkg::*;
#(
    parameter int unsigned SUB_W   = SUB_BLK_BIT,
    parameter int unsigned NUM_SUB = PPA_NUM_SUB,
    parameter int unsigned LAT     = PPA_LAT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [SUB_W-1:0]         subBlki,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_SUB*SUB_W-1:0] out_data,
    output logic                     out_bank
`ifdef PPA_PARITY_EN
    ,
    output logic [NUM_SUB-1:0]       out_parity
`endif
);

    localparam int unsigned CW = ppa_log2(NUM_SUB);
    localparam logic [CW-1:0] LAST = CW'(NUM_SUB - 1);

    logic [CW-1:0] icnt_q;
    logic [CW-1:0] wcnt_q;
    logic [1:0]    reserved_q;
    logic [1:0]    full_q;
    bank_e         wsel_q;
    bank_e         rsel_q;

    logic [NUM_SUB-1:0][SUB_W-1:0] bank_q [2];

    logic accept;
    logic do_reserve;
    logic do_release;
    logic dv;

    // A started line is never stalled; only a line start needs a free bank credit.
    assign issue_ready = (icnt_q != '0) || (reserved_q < 2'd2);
    assign accept      = issue_valid && issue_ready;
    assign do_reserve  = accept && (icnt_q == '0);

    assign out_valid  = full_q[rsel_q];
    assign do_release = out_valid && out_ready;
    assign out_data   = bank_q[rsel_q];
    assign out_bank   = rsel_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            icnt_q     <= '0;
            reserved_q <= '0;
        end else begin
            if (accept) begin
                icnt_q <= (icnt_q == LAST) ? '0 : icnt_q + CW'(1);
            end
            if (do_reserve && !do_release && (reserved_q != 2'd2)) begin
                reserved_q <= reserved_q + 2'd1;
            end else if (do_release && !do_reserve && (reserved_q != 2'd0)) begin
                reserved_q <= reserved_q - 2'd1;
            end
        end
    end

    ppa_delay_line #(
        .LAT(LAT)
    ) u_delay (
        .clk  (clk),
        .reset(reset),
        .din  (accept),
        .dout (dv)
    );

    // Credits guarantee the write bank is never the full bank being presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt_q    <= '0;
            wsel_q    <= BankPing;
            rsel_q    <= BankPing;
            full_q    <= '0;
            bank_q[0] <= '0;
            bank_q[1] <= '0;
        end else begin
            if (do_release) begin
                full_q[rsel_q] <= 1'b0;
                rsel_q         <= bank_e'(~rsel_q);
            end
            if (dv) begin
                bank_q[wsel_q][wcnt_q] <= subBlki;
                if (wcnt_q == LAST) begin
                    full_q[wsel_q] <= 1'b1;
                    wsel_q         <= bank_e'(~wsel_q);
                    wcnt_q         <= '0;
                end else begin
                    wcnt_q <= wcnt_q + CW'(1);
                end
            end
        end
    end

`ifdef PPA_PARITY_EN
    logic [NUM_SUB-1:0] par_q [2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q[0] <= '0;
            par_q[1] <= '0;
        end else if (dv) begin
            par_q[wsel_q][wcnt_q] <= ^subBlki;
        end
    end

    assign out_parity = par_q[rsel_q];
`endif

endmodule

// File: tb/tb_pingpong_blk_assembler.sv
// Self-checking bench: table-driven line scenarios, then backpressure, reserve/release,
// mid-line reset and (with PPA_PARITY_EN) parity sequences against a tag scoreboard.
module tb_pingpong_blk_assembler;

    localparam int SUB_W   = 32;
    localparam int NUM_SUB = 16;
    localparam int LAT     = 6;
    localparam int MAXC    = 512;

    logic                     clk = 1'b0;
    logic                     reset = 1'b0;
    logic                     issue_valid = 1'b0;
    logic                     issue_ready;
    logic [SUB_W-1:0]         sub_blki = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [NUM_SUB*SUB_W-1:0] out_data;
    logic                     out_bank;
`ifdef PPA_PARITY_EN
    logic [NUM_SUB-1:0]       out_parity;
`endif

    always #5 clk = ~clk;

    pingpong_blk_assembler #(
        .SUB_W  (SUB_W),
        .NUM_SUB(NUM_SUB),
        .LAT    (LAT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .subBlki    (sub_blki),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_bank   (out_bank)
`ifdef PPA_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_acc = 0;
    logic [SUB_W-1:0] tag = '0;
    logic [SUB_W-1:0] exp_q [$];
    logic             exp_rbank = 1'b0;
    logic [SUB_W-1:0] sched_d [0:MAXC-1];
    bit               sched_v [0:MAXC-1];

    typedef struct {
        int          period;
        logic [31:0] base;
        int          exp_ov;
    } line_vec_t;

    line_vec_t lines [3];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Emulates the mux stage: the tag of an accept appears on subBlki LAT cycles later.
    task automatic drive_sub();
        if (cyc < MAXC && sched_v[cyc]) sub_blki = sched_d[cyc];
        else sub_blki = 32'hDEAD_0000 | 32'(cyc);
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic check_block();
        logic [SUB_W-1:0] e;
        if (exp_q.size() < NUM_SUB) begin
            chk("blk_avail", 64'(exp_q.size()), 64'(NUM_SUB));
            return;
        end
        chk("out_bank", 64'(out_bank), 64'(exp_rbank));
        for (int k = 0; k < NUM_SUB; k++) begin
            e = exp_q.pop_front();
            chk($sformatf("slice%0d", k), 64'(out_data[k*SUB_W +: SUB_W]), 64'(e));
`ifdef PPA_PARITY_EN
            chk($sformatf("parity%0d", k), 64'(out_parity[k]), 64'(^e));
`endif
        end
        exp_rbank = ~exp_rbank;
    endtask

    // Call after sample() in the current cycle; records handshakes, then advances one cycle.
    task automatic next_cycle();
        if (issue_valid && issue_ready) begin
            if (cyc + LAT < MAXC) begin
                sched_v[cyc+LAT] = 1'b1;
                sched_d[cyc+LAT] = tag;
            end
            exp_q.push_back(tag);
            n_acc++;
        end
        if (out_valid && out_ready) check_block();
        @(posedge clk);
        #1;
        cyc++;
        drive_sub();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        issue_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data_or", 64'(|out_data), 64'd0);
        chk("rst_out_bank", 64'(out_bank), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < MAXC; i++) sched_v[i] = 1'b0;
        exp_q.delete();
        exp_rbank = 1'b0;
        n_acc = 0;
        cyc = 0;
        drive_sub();
    endtask

    initial begin
        lines[0] = '{1, 32'h100, 22};
        lines[1] = '{2, 32'hA0, 37};
        lines[2] = '{3, 32'h300, 52};

        // Single lines at various issue densities, consumer always ready.
        for (int v = 0; v < 3; v++) begin
            int first_ov;
            first_ov = -1;
            do_reset();
            out_ready = 1'b1;
            while (cyc < 120) begin
                issue_valid = ((cyc % lines[v].period) == 0) && (n_acc < NUM_SUB);
                tag = lines[v].base + 32'(n_acc);
                sample();
                if (out_valid && first_ov < 0) first_ov = cyc;
                else if (first_ov >= 0 && cyc == first_ov + 1)
                    chk("line_ov_drop", 64'(out_valid), 64'd0);
                next_cycle();
            end
            chk($sformatf("line%0d_first_ov", v), 64'(first_ov), 64'(lines[v].exp_ov));
            chk("line_drained", 64'(exp_q.size()), 64'd0);
        end

        // Double-buffer backpressure; also a release meeting a line start with reserved=2.
        do_reset();
        while (cyc < 72) begin
            issue_valid = (n_acc < 48);
            out_ready = (cyc >= 40);
            tag = 32'h200 + 32'(n_acc);
            sample();
            if (cyc == 22) chk("bp_ov22", 64'(out_valid), 64'd1);
            if (cyc == 31) chk("bp_ir31", 64'(issue_ready), 64'd1);
            if (cyc == 32) chk("bp_ir32", 64'(issue_ready), 64'd0);
            if (cyc == 40) chk("bp_ir40", 64'(issue_ready), 64'd0);
            if (cyc == 41) chk("bp_ir41", 64'(issue_ready), 64'd1);
            if (cyc == 62) chk("bp_ov62", 64'(out_valid), 64'd0);
            if (cyc == 63) begin
                chk("bp_ov63", 64'(out_valid), 64'd1);
                chk("bp_bank63", 64'(out_bank), 64'd0);
            end
            next_cycle();
        end
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        // Release and reserving accept in the same cycle with reserved=1.
        do_reset();
        while (cyc < 90) begin
            issue_valid = (cyc < 16) || (cyc >= 25 && n_acc < 48);
            out_ready = (cyc == 25) || (cyc >= 70);
            tag = 32'h400 + 32'(n_acc);
            sample();
            if (cyc == 24) chk("rr_ov24", 64'(out_valid), 64'd1);
            if (cyc == 25) chk("rr_ir25", 64'(issue_ready), 64'd1);
            if (cyc == 41) chk("rr_ir41", 64'(issue_ready), 64'd1);
            if (cyc == 57) chk("rr_ir57", 64'(issue_ready), 64'd0);
            next_cycle();
        end
        chk("rr_drained", 64'(exp_q.size()), 64'd0);

        // Reset with six sub-blocks still in flight; stale subBlki must be ignored.
        do_reset();
        out_ready = 1'b1;
        while (cyc < 60) begin
            if (cyc == 8) begin
                reset = 1'b0;
                exp_q.delete();
                n_acc = 0;
            end
            if (cyc == 10) reset = 1'b1;
            issue_valid = (cyc < 8) || (cyc >= 10 && n_acc < NUM_SUB);
            tag = (cyc < 8) ? 32'hBAD0 + 32'(n_acc) : 32'h500 + 32'(n_acc);
            sample();
            if (cyc == 8 || cyc == 9) begin
                chk("mr_ir", 64'(issue_ready), 64'd1);
                chk("mr_ov", 64'(out_valid), 64'd0);
                chk("mr_data_or", 64'(|out_data), 64'd0);
            end
            if (cyc == 31) chk("mr_ov31", 64'(out_valid), 64'd0);
            if (cyc == 32) begin
                chk("mr_ov32", 64'(out_valid), 64'd1);
                chk("mr_bank32", 64'(out_bank), 64'd0);
            end
            next_cycle();
        end
        chk("mr_drained", 64'(exp_q.size()), 64'd0);

`ifdef PPA_PARITY_EN
        do_reset();
        while (cyc < 30) begin
            issue_valid = (n_acc < NUM_SUB);
            out_ready = (cyc >= 25);
            tag = (n_acc == 3) ? 32'h1 : (n_acc == 5) ? 32'h3 : 32'h0;
            sample();
            if (cyc == 23) chk("par_out", 64'(out_parity), 64'h0008);
            next_cycle();
        end
        chk("par_drained", 64'(exp_q.size()), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
